// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction handshake bundle between instruction source and sequencer
interface alu_sequencer_if;
    logic        inst_valid;
    logic [15:0] inst_in;
    logic        inst_ready;

    modport master (output inst_valid, output inst_in, input inst_ready);
    modport slave  (input inst_valid, input inst_in, output inst_ready);
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - DECODE/EXEC/WB sequencer driving the ALU/register-file control inputs
module alu_sequencer (
    input  logic                 clk,
    input  logic                 Reset,
    alu_sequencer_if.slave       inst_bus,
    input  logic                 hold,
    input  logic [4:0]           flags_in,
    output logic [3:0]           A_Mux_input,
    output logic [3:0]           B_Mux_input,
    output logic                 Imm_mux_input,
    output logic [15:0]          Immediate,
    output logic [7:0]           OP,
    output logic                 cin,
    output logic                 Flags_Enable,
    output logic                 Tri_Enable,
    output logic [3:0]           Reg_Enable,
    output logic                 done,
    output logic [15:0]          retired
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_cmp, w_cmp_nxt;
    logic [3:0]  r_a, w_a_nxt;
    logic [3:0]  r_b, w_b_nxt;
    logic [3:0]  r_rd, w_rd_nxt;
    logic        r_isel, w_isel_nxt;
    logic [15:0] r_imm, w_imm_nxt;
    logic [7:0]  r_op, w_op_nxt;
    logic        r_cin, w_cin_nxt;
    logic        r_fen, w_fen_nxt;
    logic        r_ten, w_ten_nxt;
    logic        r_done, w_done_nxt;
    logic [15:0] r_retired, w_retired_nxt;
    logic        w_clear;

    logic        w_in_reg_form;
    logic [3:0]  w_in_code;
    logic        w_accept;
    logic        w_unused_flags;

    // Only the carry flag feeds the sequencer; the rest of the flag bus is ignored.
    assign w_unused_flags = ^flags_in[4:1];

    assign inst_bus.inst_ready = (r_state == S_IDLE) & ~hold & ~Reset;
    assign w_accept            = inst_bus.inst_valid & inst_bus.inst_ready;

    // Register form carries its ALU function in ext, immediate form in op.
    assign w_in_reg_form = (inst_bus.inst_in[15:12] == 4'h0);
    assign w_in_code     = w_in_reg_form ? inst_bus.inst_in[7:4] : inst_bus.inst_in[15:12];

    always_comb begin
        w_state_nxt   = r_state;
        w_cmp_nxt     = r_cmp;
        w_a_nxt       = r_a;
        w_b_nxt       = r_b;
        w_rd_nxt      = r_rd;
        w_isel_nxt    = r_isel;
        w_imm_nxt     = r_imm;
        w_op_nxt      = r_op;
        w_cin_nxt     = r_cin;
        w_fen_nxt     = r_fen;
        w_ten_nxt     = r_ten;
        w_done_nxt    = r_done;
        w_retired_nxt = r_retired;
        w_clear       = 1'b0;

        if (!hold) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = S_DECODE;
                        w_cmp_nxt   = (w_in_code == 4'hB);
                        w_a_nxt     = inst_bus.inst_in[11:8];
                        w_rd_nxt    = inst_bus.inst_in[11:8];
                        w_b_nxt     = w_in_reg_form ? inst_bus.inst_in[3:0] : 4'h0;
                        w_isel_nxt  = ~w_in_reg_form;
                        w_imm_nxt   = w_in_reg_form ? 16'h0000
                                                    : {{8{inst_bus.inst_in[7]}}, inst_bus.inst_in[7:0]};
                        w_op_nxt    = w_in_reg_form ? {4'h0, inst_bus.inst_in[7:4]}
                                                    : {inst_bus.inst_in[15:12], 4'h0};
                        w_cin_nxt   = (w_in_code == 4'h7) & flags_in[0];
                    end
                end
                S_DECODE: begin
                    w_state_nxt = S_EXEC;
                    w_fen_nxt   = 1'b1;
                    if (r_cmp) begin
                        w_done_nxt    = 1'b1;
                        w_retired_nxt = r_retired + 16'd1;
                    end
                end
                S_EXEC: begin
                    if (r_cmp) begin
                        w_state_nxt = S_IDLE;
                        w_clear     = 1'b1;
                    end else begin
                        w_state_nxt   = S_WB;
                        w_fen_nxt     = 1'b0;
                        w_ten_nxt     = 1'b1;
                        w_done_nxt    = 1'b1;
                        w_retired_nxt = r_retired + 16'd1;
                    end
                end
                S_WB: begin
                    w_state_nxt = S_IDLE;
                    w_clear     = 1'b1;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_clear     = 1'b1;
                end
            endcase
        end

        // Returning to IDLE parks every datapath control at zero.
        if (w_clear) begin
            w_cmp_nxt  = 1'b0;
            w_a_nxt    = 4'h0;
            w_b_nxt    = 4'h0;
            w_rd_nxt   = 4'h0;
            w_isel_nxt = 1'b0;
            w_imm_nxt  = 16'h0000;
            w_op_nxt   = 8'h00;
            w_cin_nxt  = 1'b0;
            w_fen_nxt  = 1'b0;
            w_ten_nxt  = 1'b0;
            w_done_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_cmp     <= 1'b0;
            r_a       <= 4'h0;
            r_b       <= 4'h0;
            r_rd      <= 4'h0;
            r_isel    <= 1'b0;
            r_imm     <= 16'h0000;
            r_op      <= 8'h00;
            r_cin     <= 1'b0;
            r_fen     <= 1'b0;
            r_ten     <= 1'b0;
            r_done    <= 1'b0;
            r_retired <= 16'h0000;
        end else begin
            r_state   <= w_state_nxt;
            r_cmp     <= w_cmp_nxt;
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            r_rd      <= w_rd_nxt;
            r_isel    <= w_isel_nxt;
            r_imm     <= w_imm_nxt;
            r_op      <= w_op_nxt;
            r_cin     <= w_cin_nxt;
            r_fen     <= w_fen_nxt;
            r_ten     <= w_ten_nxt;
            r_done    <= w_done_nxt;
            r_retired <= w_retired_nxt;
        end
    end

    assign A_Mux_input   = r_a;
    assign B_Mux_input   = r_b;
    assign Imm_mux_input = r_isel;
    assign Immediate     = r_imm;
    assign OP            = r_op;
    assign cin           = r_cin;
    assign Flags_Enable  = r_fen;
    assign Tri_Enable    = r_ten;
    assign Reg_Enable    = r_rd;
    assign done          = r_done;
    assign retired       = r_retired;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        Reset;
    logic        hold;
    logic [4:0]  flags_in;
    logic [3:0]  A_Mux_input, B_Mux_input, Reg_Enable;
    logic        Imm_mux_input, cin, Flags_Enable, Tri_Enable, done;
    logic [15:0] Immediate, retired;
    logic [7:0]  OP;

    alu_sequencer_if inst_bus ();

    alu_sequencer dut (
        .clk           (clk),
        .Reset         (Reset),
        .inst_bus      (inst_bus),
        .hold          (hold),
        .flags_in      (flags_in),
        .A_Mux_input   (A_Mux_input),
        .B_Mux_input   (B_Mux_input),
        .Imm_mux_input (Imm_mux_input),
        .Immediate     (Immediate),
        .OP            (OP),
        .cin           (cin),
        .Flags_Enable  (Flags_Enable),
        .Tri_Enable    (Tri_Enable),
        .Reg_Enable    (Reg_Enable),
        .done          (done),
        .retired       (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  op;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  rd;
        logic        isel;
        logic [15:0] imm;
        logic        cin;
        logic        cmp;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] exp_ret;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [15:0] w, input logic [4:0] f);
        exp_t       e;
        logic [3:0] code;
        e.rd = w[11:8];
        e.a  = w[11:8];
        if (w[15:12] == 4'h0) begin
            code   = w[7:4];
            e.op   = {4'h0, w[7:4]};
            e.b    = w[3:0];
            e.isel = 1'b0;
            e.imm  = 16'h0000;
        end else begin
            code   = w[15:12];
            e.op   = {w[15:12], 4'h0};
            e.b    = 4'h0;
            e.isel = 1'b1;
            e.imm  = {{8{w[7]}}, w[7:0]};
        end
        e.cin = (code == 4'h7) & f[0];
        e.cmp = (code == 4'hB);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!Reset && done) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("sb_op",   OP, mon_e.op);
                check("sb_a",    A_Mux_input, mon_e.a);
                check("sb_b",    B_Mux_input, mon_e.b);
                check("sb_isel", Imm_mux_input, mon_e.isel);
                check("sb_imm",  Immediate, mon_e.imm);
                check("sb_cin",  cin, mon_e.cin);
                check("sb_rd",   Reg_Enable, mon_e.rd);
                check("sb_tri",  Tri_Enable, !mon_e.cmp);
                exp_ret = exp_ret + 16'd1;
                check("sb_retired", retired, exp_ret);
            end
        end
    end

    task automatic send(input logic [15:0] w, input int holds, input bit abort_wb);
        exp_t e;
        int   guard;
        e = model(w, flags_in);
        guard = 0;
        while (!inst_bus.inst_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", inst_bus.inst_ready, 1);
        inst_bus.inst_valid = 1'b1;
        inst_bus.inst_in    = w;
        @(posedge clk);
        sb.push_back(e);
        #1 inst_bus.inst_valid = 1'b0;

        @(negedge clk);
        check("c1_a",     A_Mux_input, e.a);
        check("c1_op",    OP, e.op);
        check("c1_fen",   Flags_Enable, 0);
        check("c1_ready", inst_bus.inst_ready, 0);
        check("c1_cin",   cin, e.cin);

        @(negedge clk);
        check("c2_fen",  Flags_Enable, 1);
        check("c2_ten",  Tri_Enable, 0);
        check("c2_done", done, e.cmp);
        check("c2_cin",  cin, e.cin);

        if (holds > 0) begin
            hold                = 1'b1;
            inst_bus.inst_valid = 1'b1;
            inst_bus.inst_in    = 16'h0ABC;
            for (int k = 0; k < holds; k++) begin
                @(negedge clk);
                check("hold_fen",   Flags_Enable, 1);
                check("hold_ten",   Tri_Enable, 0);
                check("hold_ready", inst_bus.inst_ready, 0);
                check("hold_done",  done, 0);
            end
            hold                = 1'b0;
            inst_bus.inst_valid = 1'b0;
        end

        @(negedge clk);
        if (e.cmp) begin
            check("c3_cmp_ten",   Tri_Enable, 0);
            check("c3_cmp_fen",   Flags_Enable, 0);
            check("c3_cmp_done",  done, 0);
            check("c3_cmp_ready", inst_bus.inst_ready, 1);
            check("c3_cmp_a",     A_Mux_input, 0);
        end else begin
            check("c3_ten",  Tri_Enable, 1);
            check("c3_done", done, 1);
            check("c3_fen",  Flags_Enable, 0);
            check("c3_rd",   Reg_Enable, e.rd);
            check("c3_cin",  cin, e.cin);
            if (!abort_wb) begin
                @(negedge clk);
                check("c4_ready", inst_bus.inst_ready, 1);
                check("c4_ten",   Tri_Enable, 0);
                check("c4_rd",    Reg_Enable, 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset               = 1'b1;
        hold                = 1'b0;
        flags_in            = 5'b0;
        inst_bus.inst_valid = 1'b0;
        inst_bus.inst_in    = 16'h0000;
        exp_ret             = 16'h0000;

        @(negedge clk);
        @(negedge clk);
        check("rst_ready", inst_bus.inst_ready, 0);
        check("rst_a",     A_Mux_input, 0);
        check("rst_op",    OP, 0);
        check("rst_imm",   Immediate, 0);
        check("rst_fen",   Flags_Enable, 0);
        check("rst_ten",   Tri_Enable, 0);
        check("rst_done",  done, 0);
        check("rst_ret",   retired, 0);
        Reset = 1'b0;
        #1 check("post_rst_ready", inst_bus.inst_ready, 1);

        send(16'h0512, 0, 1'b1);
        #2 Reset = 1'b1;
        #1;
        check("abort_ten",  Tri_Enable, 0);
        check("abort_done", done, 0);
        check("abort_rd",   Reg_Enable, 0);
        check("abort_ret",  retired, 0);
        sb.delete();
        exp_ret = 16'h0000;
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);

        send(16'h0512, 0, 1'b0);
        check("ret_after_add", retired, 1);
        send(16'h53F0, 0, 1'b0);
        send(16'hB47F, 0, 1'b0);
        flags_in = 5'b00001;
        send(16'h0170, 0, 1'b0);
        flags_in = 5'b00000;
        send(16'h0170, 0, 1'b0);
        flags_in = 5'b11111;
        send(16'h7205, 0, 1'b0);
        send(16'h0512, 0, 1'b0);
        send(16'h2310, 3, 1'b0);
        flags_in = 5'b00000;

        hold                = 1'b1;
        inst_bus.inst_valid = 1'b1;
        inst_bus.inst_in    = 16'h0999;
        #1 check("idle_hold_ready", inst_bus.inst_ready, 0);
        @(negedge clk);
        check("idle_hold_a",   A_Mux_input, 0);
        check("idle_hold_fen", Flags_Enable, 0);
        inst_bus.inst_valid = 1'b0;
        hold                = 1'b0;
        @(negedge clk);
        check("idle_hold_a2", A_Mux_input, 0);
        check("idle_hold_done", done, 0);

        force dut.r_retired = 16'hFFFF;
        #1 release dut.r_retired;
        exp_ret = 16'hFFFF;
        check("preload", retired, 16'hFFFF);
        send(16'h1101, 0, 1'b0);
        check("wrap", retired, 0);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
